dot_product_engine: RTL and testbench
=====================================

Name: dot_product_engine

Overview:
- Sequencer and MAC stage directly downstream of the two operand memories (mem1/mem2) in the dotProduct datapath.
- On start, it walks a shared read address over both memories and multiplies the returned words pairwise. It accumulates the products and presents the dot product on a valid/ready result port.
- It owns the memories' read side (read_en/read_address). Memory data_out is registered with exactly 1 cycle read latency.

Parameters:
- DATA_WIDTH, 8, operand word width (matches memory data_out).
- ADDR_WIDTH, 4, memory read address width.
- ACC_WIDTH, 20, accumulator/result width. Must be >= 2*DATA_WIDTH+ADDR_WIDTH for overflow-free operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  pulse; request a new dot product
- len_m1  in  ADDR_WIDTH  vector length minus 1; sampled when start is accepted
- busy  out  1  high from accepted start until result handshake completes
- rd_en  out  1  read enable to both memories
- rd_addr  out  ADDR_WIDTH  shared read address to both memories
- rd_data_a  in  DATA_WIDTH  data_out of operand memory A
- rd_data_b  in  DATA_WIDTH  data_out of operand memory B
- result  out  ACC_WIDTH  dot product
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk.
- Reset values: state IDLE, busy=0, rd_en=0, rd_addr=0, result=0, result_valid=0; accumulator, counter and pipeline valid flag cleared.
- Reset mid-operation: abort immediately to IDLE. No partial result is emitted.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 accepted at edge k: capture len_m1, clear accumulator, go to FETCH, busy=1.
  - start while busy is ignored, including in DONE.
- FETCH:
  - Each cycle, assert rd_en=1 with rd_addr = i, for i = 0..len_m1. Addresses 0..N-1 are issued on cycles k+1..k+N.
  - A 1-bit valid flag delays rd_en by 1 cycle. When the flag is set, acc <= acc + rd_data_a*rd_data_b.
  - After issuing addr len_m1, go to DRAIN with rd_en=0.
- DRAIN: one cycle to accumulate the final product, then go to DONE.
- DONE:
  - result=acc and result_valid=1 from cycle k+N+2, where N=len_m1+1.
  - Both are held stable until result_valid&&result_ready. Then return to IDLE; result_valid and busy drop on the next cycle.
  - A start on that same handshake cycle is ignored. A new start is accepted in IDLE from the following cycle.
- len_m1=0 is a valid single-element vector. len_m1 = 2^ADDR_WIDTH-1 covers the full address space, and rd_addr must not wrap before termination.
- Arithmetic:
  - Default is unsigned: product is 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH.
  - The accumulator wraps modulo 2^ACC_WIDTH with no saturation.
- rd_addr holds its last value when rd_en=0.

Optional Feature:
- Macro DOT_SIGNED_EN.
- Defined: operands are two's complement, the product is sign-extended to ACC_WIDTH, and result is signed.
- Undefined: unsigned operands and zero-extension as above.
- Interface and timing are identical in both builds.

Decomposition:
- Package dot_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, DONE);
  - default width constants;
  - a function for the minimum ACC_WIDTH from DATA_WIDTH and ADDR_WIDTH.
- One sub-module, dot_mac: registered multiply-accumulate with clear and enable inputs. The DOT_SIGNED_EN selection lives there.
- FSM and address counter stay in dot_product_engine.

Test Plan:
- Both memories all 1, len_m1=15, start -> 16 rd_en cycles with addrs 0..15; result=16; result_valid rises exactly 18 cycles after start edge.
- A[i]=i, B[i]=2, len_m1=3 -> result=12; rd_addr sequence 0,1,2,3.
- All operands 255, len_m1=15 -> result=1040400, no wrap.
- Result backpressure: result_ready low 5 cycles after valid -> result and result_valid stable throughout; start pulses during DONE ignored; one accepted handshake only.
- rst_n low for 1 cycle during FETCH at i=5 -> next cycle IDLE, busy=0, rd_en=0. A following start with all-1 data and len_m1=0 -> result=1.
- DOT_SIGNED_EN defined: A=-1 (8'hFF), B=1, len_m1=3 -> result=20'hFFFFC (-4). Same stimulus with the macro undefined -> result=1020.

Source files
------------

// File: rtl/dot_pkg.sv
// ============================================================================
// Module      : dot_pkg
// Description : Shared types and width constants for the dot-product engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_pkg;

    localparam int C_DATA_WIDTH = 8;
    localparam int C_ADDR_WIDTH = 4;
    localparam int C_ACC_WIDTH  = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dot_state_e;

    // Smallest accumulator that cannot overflow for a full-length vector.
    function automatic int min_acc_width(input int data_width, input int addr_width);
        return 2 * data_width + addr_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dot_mac.sv
// ============================================================================
// Module      : dot_mac
// Description : Registered multiply-accumulate with synchronous clear/enable.
//               Define DOT_SIGNED_EN for two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_mac
    import dot_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ACC_WIDTH  = C_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] w_a_ext;
    logic [2*DATA_WIDTH-1:0] w_b_ext;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic                    w_ext_bit;
    logic [ACC_WIDTH-1:0]    w_prod_ext;
    logic [ACC_WIDTH-1:0]    r_acc;

    // Operands are widened to the product width first, so the low 2*DATA_WIDTH
    // bits of an unsigned multiply are also the exact signed product.
`ifdef DOT_SIGNED_EN
    assign w_a_ext   = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign w_b_ext   = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign w_ext_bit = w_prod[2*DATA_WIDTH-1];
`else
    assign w_a_ext   = {{DATA_WIDTH{1'b0}}, a};
    assign w_b_ext   = {{DATA_WIDTH{1'b0}}, b};
    assign w_ext_bit = 1'b0;
`endif

    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_ext_bit}}, w_prod};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/dot_product_engine.sv
// ============================================================================
// Module      : dot_product_engine
// Description : Walks a shared read address over two operand memories and
//               accumulates the pairwise products. DOT_SIGNED_EN selects
//               signed arithmetic inside dot_mac.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_engine
    import dot_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int ACC_WIDTH  = C_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len_m1,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    if (ACC_WIDTH < min_acc_width(DATA_WIDTH, ADDR_WIDTH)) begin : g_acc_width_chk
        $error("ACC_WIDTH too small for overflow-free accumulation");
    end

    dot_state_e            r_state;
    dot_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_len_m1;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
    logic                  r_rd_en;
    logic                  w_rd_en_nxt;
    logic                  r_pipe_vld;
    logic                  w_start_acc;
    logic [ACC_WIDTH-1:0]  w_acc;

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_en_nxt   = r_rd_en;
        w_rd_addr_nxt = r_rd_addr;
        w_start_acc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc   = 1'b1;
                    w_state_nxt   = FETCH;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = '0;
                end
            end
            FETCH: begin
                // Stop on equality so a full-range vector never wraps the address.
                if (r_rd_addr == r_len_m1) begin
                    w_state_nxt = DRAIN;
                    w_rd_en_nxt = 1'b0;
                end else begin
                    w_rd_addr_nxt = r_rd_addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (result_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_len_m1   <= '0;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_pipe_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_pipe_vld <= r_rd_en;
            if (w_start_acc) begin
                r_len_m1 <= len_m1;
            end
        end
    end

    // r_pipe_vld tracks the one-cycle memory read latency.
    dot_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_acc),
        .en    (r_pipe_vld),
        .a     (rd_data_a),
        .b     (rd_data_b),
        .acc   (w_acc)
    );

    assign busy         = (r_state != IDLE);
    assign rd_en        = r_rd_en;
    assign rd_addr      = r_rd_addr;
    assign result       = w_acc;
    assign result_valid = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_dot_product_engine.sv
// ============================================================================
// Module      : tb_dot_product_engine
// Description : Scoreboard bench for dot_product_engine with registered
//               operand memories and a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_product_engine;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] len_m1 = '0;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a = '0;
    logic [DW-1:0] rd_data_b = '0;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b1;

    dot_product_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len_m1       (len_m1),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories with one cycle of registered read latency.
    logic [DW-1:0] mem_a [1<<AW];
    logic [DW-1:0] mem_b [1<<AW];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    typedef struct {
        logic [CW-1:0] exp;
        int            n;
        int            start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pushed = 0;
    int   n_hs = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Dot product from the memory contents, wrapped to the result width.
    function automatic logic [CW-1:0] ref_dot(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
`ifdef DOT_SIGNED_EN
            s += longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
`else
            s += longint'(mem_a[i]) * longint'(mem_b[i]);
`endif
        end
        return s[CW-1:0];
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < (1 << AW); i++) begin
            case (mode)
                0:       begin mem_a[i] = 8'd1;      mem_b[i] = 8'd1;      end
                1:       begin mem_a[i] = DW'(i);    mem_b[i] = 8'd2;      end
                2:       begin mem_a[i] = 8'hFF;     mem_b[i] = 8'hFF;     end
                3:       begin mem_a[i] = 8'hFF;     mem_b[i] = 8'd1;      end
                default: begin mem_a[i] = DW'($urandom); mem_b[i] = DW'($urandom); end
            endcase
        end
    endtask

    task automatic issue(input int len, input bit push);
        exp_t e;
        @(posedge clk); #1;
        start  = 1'b1;
        len_m1 = AW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            e.exp       = ref_dot(len + 1);
            e.n         = len + 1;
            e.start_cyc = cyc;
            exp_q.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 300);
        if (busy) check("idle timeout", 1, 0);
    endtask

    task automatic run_op(input int mode, input int len);
        fill(mode);
        issue(len, 1'b1);
        wait_idle();
    endtask

    // Monitor: address walk, valid latency, hold-under-backpressure, results.
    initial begin : monitor
        int            addr_idx = 0;
        bit            prev_valid = 1'b0;
        bit            prev_hs = 1'b0;
        logic [CW-1:0] prev_result = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                addr_idx   = 0;
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                continue;
            end
            if (!busy) addr_idx = 0;
            if (rd_en) begin
                check("rd_addr", longint'(rd_addr), addr_idx);
                addr_idx++;
            end
            if (prev_valid && !prev_hs) begin
                check("valid held", result_valid, 1);
                check("result held", result, prev_result);
            end
            if (result_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected valid", result_valid, 0);
                end else begin
                    check("valid latency", cyc - exp_q[0].start_cyc, exp_q[0].n + 1);
                    check("rd_en count", addr_idx, exp_q[0].n);
                end
            end
            if (result_valid && result_ready) begin
                n_hs++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", result, e.exp);
                end
            end
            prev_valid  = result_valid;
            prev_hs     = result_valid && result_ready;
            prev_result = result;
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rand_ready) result_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int t;
        fill(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset rd_en", rd_en, 0);
        check("reset rd_addr", rd_addr, 0);
        check("reset result", result, 0);
        check("reset result_valid", result_valid, 0);

        run_op(0, 15);
        run_op(1, 3);
        run_op(2, 15);
        run_op(3, 3);
        run_op(0, 0);

        // Backpressure with ignored start pulses, including on the handshake cycle.
        fill(1);
        result_ready = 1'b0;
        issue(7, 1'b1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!result_valid && t < 100);
        if (!result_valid) check("valid timeout", 1, 0);
        repeat (5) begin
            @(posedge clk); #1;
            start = ~start;
        end
        @(posedge clk); #1;
        result_ready = 1'b1;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy after handshake", busy, 0);
        check("valid after handshake", result_valid, 0);
        @(negedge clk);
        check("start on handshake ignored", busy, 0);

        // Abort mid-FETCH, then a single-element vector.
        fill(0);
        issue(15, 1'b0);
        t = 0;
        while (!(rd_en && rd_addr == AW'(5)) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("reached addr 5", rd_addr, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort rd_en", rd_en, 0);
        check("abort result_valid", result_valid, 0);
        run_op(0, 0);

        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            run_op(4, (i % 6 == 0) ? 15 : int'($urandom_range(0, 15)));
        end
        rand_ready   = 1'b0;
        result_ready = 1'b1;
        repeat (4) @(negedge clk);

        check("scoreboard drained", exp_q.size(), 0);
        check("handshake count", n_hs, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
